// File: rtl/aemb2_tpsram_arb_pkg.sv
// Shared types and constants for the two-requester two-port SRAM arbiter.
// Also holds a helper that selects which eligible requesters want a given port.
package aemb2_tpsram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

    // Bit n is set when requester n is eligible and its access type matches typ.
    function automatic logic [1:0] req_by_type(input logic [1:0] elig,
                                               input logic [1:0] we,
                                               input logic       typ);
        logic [1:0] res;
        for (int i = 0; i < 2; i++) begin
            res[i] = elig[i] & (we[i] == typ);
        end
        return res;
    endfunction

endpackage

// File: rtl/aemb2_rr_arb2.sv
// Two-way round-robin arbiter: on a conflict the requester named by pri_i wins,
// and pri_nxt_o points at the loser; otherwise the pointer is left alone.
module aemb2_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       pri_i,
    output logic [1:0] gnt_o,
    output logic       pri_nxt_o
);

    always_comb begin
        gnt_o     = 2'b00;
        pri_nxt_o = pri_i;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11: begin
                gnt_o     = pri_i ? 2'b10 : 2'b01;
                pri_nxt_o = ~pri_i;
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/aemb2_tpsram_arb.sv
// Shares one two-port SRAM (write port A, registered read port X) between two
// requesters, with an optional zero-fill of the whole array after reset.
module aemb2_tpsram_arb
    import aemb2_tpsram_arb_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = 32,
    parameter int INIT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] adr0_i,
    input  logic [DW-1:0] wdat0_i,
    output logic          ack0_o,
    output logic [DW-1:0] rdat0_o,
    input  logic          req1_i,
    input  logic          we1_i,
    input  logic [AW-1:0] adr1_i,
    input  logic [DW-1:0] wdat1_i,
    output logic          ack1_o,
    output logic [DW-1:0] rdat1_o,
    output logic          init_done_o,
    output logic          sram_wre_o,
    output logic [AW-1:0] sram_adr_o,
    output logic [DW-1:0] sram_dat_o,
    output logic          sram_xena_o,
    output logic [AW-1:0] sram_xadr_o,
    input  logic [DW-1:0] sram_xdat_i
);

    localparam state_e RST_STATE     = (INIT != 0) ? ST_INIT : ST_RUN;
    localparam logic   RST_INIT_DONE = (INIT != 0) ? 1'b0 : 1'b1;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          init_done_q, init_done_d;
    logic          pri_q, pri_d;
    logic [1:0]    ack_q, ack_d;

    logic          run;
    logic [1:0]    req_v, we_v, elig;
    logic [1:0]    wr_req, rd_req;
    logic [1:0]    gnt_wr, gnt_rd;
    logic          wr_pri_nxt, rd_pri_nxt;

    assign run   = (state_q == ST_RUN);
    assign req_v = {req1_i, req0_i};
    assign we_v  = {we1_i, we0_i};

    // A requester whose ack is going out this cycle is still holding the
    // request it was just served for, so it must not be granted again.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = run & req_v[gi] & ~ack_q[gi];
        end
    endgenerate

    assign wr_req = req_by_type(elig, we_v, REQ_WR);
    assign rd_req = req_by_type(elig, we_v, REQ_RD);

    aemb2_rr_arb2 u_wr_arb (
        .req_i     (wr_req),
        .pri_i     (pri_q),
        .gnt_o     (gnt_wr),
        .pri_nxt_o (wr_pri_nxt)
    );

    aemb2_rr_arb2 u_rd_arb (
        .req_i     (rd_req),
        .pri_i     (pri_q),
        .gnt_o     (gnt_rd),
        .pri_nxt_o (rd_pri_nxt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        pri_d       = pri_q;
        ack_d       = 2'b00;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (&cnt_q) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                ack_d = gnt_wr | gnt_rd;
                // Both requesters contend for at most one port per cycle,
                // so only one arbiter can ever want to move the pointer.
                pri_d = (wr_req == 2'b11) ? wr_pri_nxt : rd_pri_nxt;
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            init_done_q <= RST_INIT_DONE;
            pri_q       <= 1'b0;
            ack_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            pri_q       <= pri_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        sram_wre_o  = 1'b0;
        sram_adr_o  = adr0_i;
        sram_dat_o  = wdat0_i;
        sram_xena_o = |gnt_rd;
        sram_xadr_o = gnt_rd[1] ? adr1_i : adr0_i;
        if (!run) begin
            sram_wre_o = 1'b1;
            sram_adr_o = cnt_q;
            sram_dat_o = '0;
        end else begin
            sram_wre_o = |gnt_wr;
            if (gnt_wr[1]) begin
                sram_adr_o = adr1_i;
                sram_dat_o = wdat1_i;
            end
        end
    end

    assign ack0_o      = ack_q[0];
    assign ack1_o      = ack_q[1];
    assign rdat0_o     = sram_xdat_i;
    assign rdat1_o     = sram_xdat_i;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_aemb2_tpsram_arb.sv
// Directed bench for aemb2_tpsram_arb (AW=4, DW=32, INIT=1) with a behavioural
// two-port SRAM: vector table for single accesses plus multi-cycle sequences.
module tb_aemb2_tpsram_arb;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] adr0, adr1;
    logic [DW-1:0] wdat0, wdat1;
    logic          ack0, ack1, init_done;
    logic [DW-1:0] rdat0, rdat1;
    logic          sram_wre, sram_xena;
    logic [AW-1:0] sram_adr, sram_xadr;
    logic [DW-1:0] sram_dat;
    logic [DW-1:0] sram_xdat = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aemb2_tpsram_arb #(.AW(AW), .DW(DW), .INIT(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req0_i      (req0),
        .we0_i       (we0),
        .adr0_i      (adr0),
        .wdat0_i     (wdat0),
        .ack0_o      (ack0),
        .rdat0_o     (rdat0),
        .req1_i      (req1),
        .we1_i       (we1),
        .adr1_i      (adr1),
        .wdat1_i     (wdat1),
        .ack1_o      (ack1),
        .rdat1_o     (rdat1),
        .init_done_o (init_done),
        .sram_wre_o  (sram_wre),
        .sram_adr_o  (sram_adr),
        .sram_dat_o  (sram_dat),
        .sram_xena_o (sram_xena),
        .sram_xadr_o (sram_xadr),
        .sram_xdat_i (sram_xdat)
    );

    // Read-before-write SRAM: a same-cycle read of a written address sees old data.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_xena) sram_xdat <= mem[sram_xadr];
        if (sram_wre)  mem[sram_adr] <= sram_dat;
    end

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          e_wre;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic          e_xena;
        logic [AW-1:0] e_xadr;
        logic          e_ack0, e_ack1;
        logic          c_rd0;
        logic [DW-1:0] e_rd0;
        logic          c_rd1;
        logic [DW-1:0] e_rd1;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_reqs();
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0, 4'd0, 32'h0,
                    1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 4'd5, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0,
                    1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 4'd3, 32'h55,
                    1'b1, 4'd3, 32'h55, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 4'd7, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0,
                    1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 4'd3, 32'hAA, 1'b1, 1'b0, 4'd3, 32'h0,
                    1'b1, 4'd3, 32'hAA, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h55};
        vecs[5] = '{1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 4'd3, 32'h0,
                    1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hAA};
        vecs[6] = '{1'b1, 1'b1, 4'd6, 32'h66, 1'b1, 1'b0, 4'd5, 32'h0,
                    1'b1, 4'd6, 32'h66, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF};
        vecs[7] = '{1'b1, 1'b0, 4'd6, 32'h0, 1'b1, 1'b1, 4'd7, 32'h77,
                    1'b1, 4'd7, 32'h77, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 32'h66, 1'b0, 32'h0};

        req0 = 1'b0; we0 = 1'b0; adr0 = '0; wdat0 = '0;
        req1 = 1'b0; we1 = 1'b0; adr1 = '0; wdat1 = '0;

        // Reset, then zero-fill with req0 held (it must not be served during fill).
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_ack0", 32'(ack0), 32'd0);
        chk("reset_ack1", 32'(ack1), 32'd0);
        chk("reset_init_done", 32'(init_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b1; adr0 = 4'd9; wdat0 = 32'h1234;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("init_wre", 32'(sram_wre), 32'd1);
            chk("init_adr", 32'(sram_adr), 32'(i));
            chk("init_dat", sram_dat, 32'd0);
            chk("init_ack0", 32'(ack0), 32'd0);
            chk("init_done_low", 32'(init_done), 32'd0);
            if (i == 15) req0 = 1'b0;
            @(posedge clk); #1;
        end
        #1;
        chk("init_done_high", 32'(init_done), 32'd1);
        chk("post_init_ack0", 32'(ack0), 32'd0);
        @(posedge clk); #1;

        // Table: grant cycle checks SRAM side, following idle cycle checks acks/data.
        for (int v = 0; v < 8; v++) begin
            req0 = vecs[v].r0; we0 = vecs[v].w0; adr0 = vecs[v].a0; wdat0 = vecs[v].d0;
            req1 = vecs[v].r1; we1 = vecs[v].w1; adr1 = vecs[v].a1; wdat1 = vecs[v].d1;
            #1;
            chk($sformatf("v%0d_wre", v), 32'(sram_wre), 32'(vecs[v].e_wre));
            if (vecs[v].e_wre) begin
                chk($sformatf("v%0d_adr", v), 32'(sram_adr), 32'(vecs[v].e_adr));
                chk($sformatf("v%0d_dat", v), sram_dat, vecs[v].e_dat);
            end
            chk($sformatf("v%0d_xena", v), 32'(sram_xena), 32'(vecs[v].e_xena));
            if (vecs[v].e_xena)
                chk($sformatf("v%0d_xadr", v), 32'(sram_xadr), 32'(vecs[v].e_xadr));
            @(posedge clk); #1;
            idle_reqs();
            #1;
            chk($sformatf("v%0d_ack0", v), 32'(ack0), 32'(vecs[v].e_ack0));
            chk($sformatf("v%0d_ack1", v), 32'(ack1), 32'(vecs[v].e_ack1));
            if (vecs[v].c_rd0) chk($sformatf("v%0d_rdat0", v), rdat0, vecs[v].e_rd0);
            if (vecs[v].c_rd1) chk($sformatf("v%0d_rdat1", v), rdat1, vecs[v].e_rd1);
            $display("vector %0d: ack0=%0b ack1=%0b rdat0=%h rdat1=%h", v, ack0, ack1, rdat0, rdat1);
            @(posedge clk); #1;
        end

        // Both write: pointer 0 -> req0 first, then req1; pointer ends at 1.
        req0 = 1'b1; we0 = 1'b1; adr0 = 4'd1; wdat0 = 32'h11;
        req1 = 1'b1; we1 = 1'b1; adr1 = 4'd2; wdat1 = 32'h22;
        #1;
        chk("ww_n_adr", 32'(sram_adr), 32'd1);
        chk("ww_n_dat", sram_dat, 32'h11);
        @(posedge clk); #1;
        req0 = 1'b0;
        #1;
        chk("ww_n1_ack0", 32'(ack0), 32'd1);
        chk("ww_n1_ack1", 32'(ack1), 32'd0);
        chk("ww_n1_wre", 32'(sram_wre), 32'd1);
        chk("ww_n1_adr", 32'(sram_adr), 32'd2);
        chk("ww_n1_dat", sram_dat, 32'h22);
        @(posedge clk); #1;
        req1 = 1'b0;
        #1;
        chk("ww_n2_ack0", 32'(ack0), 32'd0);
        chk("ww_n2_ack1", 32'(ack1), 32'd1);
        $display("dual write: done");
        @(posedge clk); #1;

        // Both read: pointer is now 1 -> req1 wins first; pointer flips back to 0.
        req0 = 1'b1; we0 = 1'b0; adr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; adr1 = 4'd2;
        #1;
        chk("rr_n_xena", 32'(sram_xena), 32'd1);
        chk("rr_n_xadr", 32'(sram_xadr), 32'd2);
        @(posedge clk); #1;
        req1 = 1'b0;
        #1;
        chk("rr_n1_ack1", 32'(ack1), 32'd1);
        chk("rr_n1_ack0", 32'(ack0), 32'd0);
        chk("rr_n1_rdat1", rdat1, 32'h22);
        chk("rr_n1_xadr", 32'(sram_xadr), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        #1;
        chk("rr_n2_ack0", 32'(ack0), 32'd1);
        chk("rr_n2_rdat0", rdat0, 32'h11);
        $display("dual read: rdat0=%h rdat1 earlier", rdat0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Held read by req0 alone (every other cycle), then req1 joins and fills gaps.
        req0 = 1'b1; we0 = 1'b0; adr0 = 4'd5;
        we1 = 1'b0; adr1 = 4'd1;
        for (int k = 0; k < 11; k++) begin
            logic       e_xena, e_ack0, e_ack1;
            logic [3:0] e_xadr;
            if (k == 6) req1 = 1'b1;
            if (k == 10) idle_reqs();
            if (k < 6) begin
                e_xena = (k % 2 == 0);
                e_xadr = 4'd5;
                e_ack0 = (k % 2 == 1);
                e_ack1 = 1'b0;
            end else begin
                e_xena = (k < 10);
                e_xadr = (k % 2 == 0) ? 4'd5 : 4'd1;
                e_ack0 = (k == 7) || (k == 9);
                e_ack1 = (k == 8) || (k == 10);
            end
            #1;
            chk($sformatf("held_k%0d_xena", k), 32'(sram_xena), 32'(e_xena));
            if (e_xena) chk($sformatf("held_k%0d_xadr", k), 32'(sram_xadr), 32'(e_xadr));
            chk($sformatf("held_k%0d_ack0", k), 32'(ack0), 32'(e_ack0));
            chk($sformatf("held_k%0d_ack1", k), 32'(ack1), 32'(e_ack1));
            if (e_ack0) chk($sformatf("held_k%0d_rdat0", k), rdat0, 32'hDEADBEEF);
            if (e_ack1) chk($sformatf("held_k%0d_rdat1", k), rdat1, 32'h11);
            $display("held cycle %0d: xena=%0b ack0=%0b ack1=%0b", k, sram_xena, ack0, ack1);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        // Reset asserted while an ack is out: acks drop at once, fill restarts at 0.
        req0 = 1'b1; we0 = 1'b0; adr0 = 4'd2;
        #1;
        chk("rst_pre_xena", 32'(sram_xena), 32'd1);
        @(posedge clk); #1;
        #1;
        chk("rst_pre_ack0", 32'(ack0), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_ack0", 32'(ack0), 32'd0);
        chk("rst_async_ack1", 32'(ack1), 32'd0);
        chk("rst_async_init_done", 32'(init_done), 32'd0);
        chk("rst_async_wre", 32'(sram_wre), 32'd1);
        chk("rst_async_adr", 32'(sram_adr), 32'd0);
        chk("rst_async_xena", 32'(sram_xena), 32'd0);
        req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("refill_wre", 32'(sram_wre), 32'd1);
            chk("refill_adr", 32'(sram_adr), 32'(i));
            chk("refill_dat", sram_dat, 32'd0);
            @(posedge clk); #1;
        end
        $display("reset mid-burst: refill restarted");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
